// File: rtl/seq_mdu.sv
// Sequential multiply/divide unit owning HI/LO: 32-iteration shift-add multiply
// and restoring divide, plus direct MTHI/MTLO writes while idle.
module seq_mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] data_x,
  input  logic [31:0] data_y,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] data_w,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 5;
  localparam int unsigned LAST = W - 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t         state_q, state_d;
  logic           div_q, div_d;
  logic           neg_res_q, neg_res_d;
  logic           neg_rem_q, neg_rem_d;
  logic           dz_q, dz_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [W-1:0]   acc_hi_q, acc_hi_d;
  logic [W-1:0]   acc_lo_q, acc_lo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_d, done_d;
  logic [W-1:0]   hi_d, lo_d;

  // Operand magnitudes; op[0]=0 selects the signed variants.
  logic           is_signed, is_div, x_neg, y_neg;
  logic [W-1:0]   abs_x, abs_y;
  assign is_signed = ~op[0];
  assign is_div    = op[1];
  assign x_neg     = is_signed & data_x[W-1];
  assign y_neg     = is_signed & data_y[W-1];
  assign abs_x     = x_neg ? W'(-data_x) : data_x;
  assign abs_y     = y_neg ? W'(-data_y) : data_y;

  // Multiply step: add multiplicand on multiplier LSB, shift right.
  logic [W:0]     mul_sum;
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : (W+1)'(0));

  // Divide step: 33-bit trial subtract of divisor from shifted remainder.
  logic [W:0]     div_shift;
  logic           div_ge;
  logic [W-1:0]   div_trial;
  assign div_shift = {acc_hi_q, acc_lo_q[W-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_trial = W'(div_shift[W-1:0] - opnd_q);

  // Sign fix-up of the finished magnitude results.
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_res_q ? (2*W)'(-{acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};
  assign quo_fix  = neg_res_q ? W'(-acc_lo_q) : acc_lo_q;
  assign rem_fix  = neg_rem_q ? W'(-acc_hi_q) : acc_hi_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      opnd_q    <= opnd_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      hi        <= hi_d;
      lo        <= lo_d;
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    opnd_d    = opnd_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    busy_d    = busy;
    done_d    = 1'b0;
    hi_d      = hi;
    lo_d      = lo;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          busy_d    = 1'b1;
          div_d     = is_div;
          neg_res_d = x_neg ^ y_neg;
          neg_rem_d = x_neg;
          dz_d      = is_div & (data_y == '0);
          opnd_d    = is_div ? abs_y : abs_x;
          acc_hi_d  = '0;
          acc_lo_d  = is_div ? abs_x : abs_y;
          cnt_d     = '0;
        end else begin
          if (hi_we) hi_d = data_w;
          if (lo_we) lo_d = data_w;
        end
      end
      RUN: begin
        if (div_q) begin
          acc_hi_d = div_ge ? div_trial : div_shift[W-1:0];
          acc_lo_d = {acc_lo_q[W-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[W:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[W-1:1]};
        end
        cnt_d = CW'(cnt_q + CW'(1));
        if (cnt_q == CW'(LAST)) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (div_q) begin
          // With a zero divisor every trial succeeds, so the remainder path
          // already rebuilds the raw dividend; only the quotient is forced.
          lo_d = dz_q ? '1 : quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_mdu.sv
// Directed and model-checked bench for seq_mdu with a result scoreboard.
module tb_seq_mdu;

  logic        clk = 1'b0;
  logic        rst, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] data_x, data_y, data_w;
  logic        busy, done;
  logic [31:0] hi, lo;

  seq_mdu dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .data_x(data_x), .data_y(data_y),
    .hi_we(hi_we), .lo_we(lo_we), .data_w(data_w),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference results {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'd0: return 64'(sx * sy);
      2'd1: return ux * uy;
      2'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Issue one op, optionally disturb inputs during RUN, then score the result.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp_hl, input string tag,
                       input bit disturb, input bit with_we);
    exp_t e;
    int   n;
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    data_x = x;
    data_y = y;
    if (with_we) begin
      hi_we  = 1'b1;
      lo_we  = 1'b1;
      data_w = 32'hDEAD_BEEF;
    end
    e.hi  = exp_hl[63:32];
    e.lo  = exp_hl[31:0];
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    check($sformatf("%s:busy_e0", tag), 32'(busy), 32'd1);
    check($sformatf("%s:done_e0", tag), 32'(done), 32'd0);
    if (with_we) begin
      check($sformatf("%s:hi_held_e0", tag), hi, last_hi);
      check($sformatf("%s:lo_held_e0", tag), lo, last_lo);
    end
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      if (disturb && i < 25) begin
        start  = 1'b1;
        hi_we  = 1'b1;
        lo_we  = 1'b1;
        op     = 2'($urandom);
        data_w = $urandom;
        data_x = $urandom;
        data_y = $urandom;
      end else begin
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
      end
      @(posedge clk);
      #1;
      if (disturb && i == 20) begin
        check($sformatf("%s:hi_hold_run", tag), hi, last_hi);
        check($sformatf("%s:lo_hold_run", tag), lo, last_lo);
      end
      if (i == 32) check($sformatf("%s:busy_e32", tag), 32'(busy), 32'd1);
      if (done) begin
        n = i;
        break;
      end
    end
    check($sformatf("%s:latency", tag), 32'(n), 32'd33);
    check($sformatf("%s:busy_done", tag), 32'(busy), 32'd0);
    e = sb.pop_front();
    check($sformatf("%s:hi", e.tag), hi, e.hi);
    check($sformatf("%s:lo", e.tag), lo, e.lo);
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx, ry;

    rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'd0; data_x = '0; data_y = '0; data_w = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset:busy", 32'(busy), 32'd0);
    check("reset:done", 32'(done), 32'd0);
    check("reset:hi", hi, 32'd0);
    check("reset:lo", lo, 32'd0);

    // MTHI alone, then both writes together.
    @(negedge clk);
    hi_we = 1'b1; data_w = 32'h0000_1234;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    check("mthi:hi", hi, 32'h0000_1234);
    check("mthi:lo", lo, 32'd0);
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; data_w = 32'hA5A5_5A5A;
    @(posedge clk);
    #1;
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthilo:hi", hi, 32'hA5A5_5A5A);
    check("mthilo:lo", lo, 32'hA5A5_5A5A);
    last_hi = 32'hA5A5_5A5A;
    last_lo = 32'hA5A5_5A5A;

    // Directed arithmetic; each issue starts in the previous done cycle.
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, "multu_max", 0, 0);
    issue(2'd0, 32'hFFFF_FFFD, 32'h0000_0005, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, "mult_neg", 0, 0);
    issue(2'd0, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000}, "mult_min", 0, 0);
    issue(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_neg", 0, 0);
    issue(2'd3, 32'd7, 32'd2, {32'd1, 32'd3}, "divu_7_2", 0, 0);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, "div_ovf", 0, 0);
    issue(2'd3, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, "divu_by0", 0, 0);
    issue(2'd2, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF}, "div_by0", 0, 0);

    // Start, writes and operand changes during RUN must not disturb the op.
    issue(2'd2, 32'h0000_1234, 32'hFFFF_FFF9, model(2'd2, 32'h0000_1234, 32'hFFFF_FFF9), "div_disturb", 1, 0);
    issue(2'd0, 32'h7654_3210, 32'h89AB_CDEF, model(2'd0, 32'h7654_3210, 32'h89AB_CDEF), "mult_disturb", 1, 0);

    // start together with hi_we/lo_we: writes dropped.
    issue(2'd1, 32'd2, 32'd3, {32'd0, 32'd6}, "start_with_we", 0, 1);

    // Reset at iteration 10 of a DIVU abandons it.
    @(negedge clk);
    start = 1'b1; op = 2'd3; data_x = 32'd1000; data_y = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst:busy", 32'(busy), 32'd0);
    check("midrst:done", 32'(done), 32'd0);
    check("midrst:hi", hi, 32'd0);
    check("midrst:lo", lo, 32'd0);
    last_hi = '0;
    last_lo = '0;
    issue(2'd1, 32'd3, 32'd4, {32'd0, 32'd12}, "multu_after_rst", 0, 0);

    // Random operands against the integer model.
    for (int k = 0; k < 8; k++) begin
      ro = 2'(k);
      rx = $urandom;
      ry = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      issue(ro, rx, ry, model(ro, rx, ry), $sformatf("rand%0d_op%0d", k, ro), 0, 0);
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
